serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer that time-shares one external 1-bit full adder (FA_dataflow) to add two WIDTH-bit operands plus carry-in.

---
 rtl/serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB first through one
// external full adder, registering the carry between bits.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             fa_A,
  output logic             fa_B,
  output logic             fa_Cin,
  input  logic             fa_S,
  input  logic             fa_Cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;

  logic              accept;
  logic              last_bit;
  logic [WIDTH-1:0]  sum_shift;

  assign accept   = start && (state_q != StRun);
  assign last_bit = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

  // Shift in the new sum bit at the MSB; written this way so WIDTH=1 needs no empty slice.
  always_comb begin
    sum_shift            = sum_sh_q >> 1;
    sum_shift[WIDTH-1]   = fa_S;
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d  = A;
      b_sh_d  = B;
      carry_d = Cin;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      sum_sh_d = sum_shift;
      carry_d  = fa_Cout;
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (last_bit) begin
        s_d    = sum_shift;
        cout_d = fa_Cout;
      end
    end
  end

  // Outputs: full-adder inputs are gated to zero outside RUN
  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    fa_A   = 1'b0;
    fa_B   = 1'b0;
    fa_Cin = 1'b0;
    if (state_q == StRun) begin
      fa_A   = a_sh_q[0];
      fa_B   = b_sh_q[0];
      fa_Cin = carry_q;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit and a 1-bit instance, each driving
// its own behavioural full adder, checked against plain-arithmetic expectations.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8;
  logic       busy8, done8, cout8;
  logic [7:0] s8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;
  logic       busy1, done1, cout1;
  logic [0:0] s1;

  int checks = 0;
  int failures = 0;

  logic [7:0] prev_s8 = '0;
  logic       prev_c8 = 1'b0;

  always #5 clk = ~clk;

  // External full adders
  assign fa_s8    = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_s1    = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .fa_A(fa_a8), .fa_B(fa_b8), .fa_Cin(fa_cin8), .fa_S(fa_s8), .fa_Cout(fa_cout8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .fa_A(fa_a1), .fa_B(fa_b1), .fa_Cin(fa_cin1), .fa_S(fa_s1), .fa_Cout(fa_cout1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle8(input string tag);
    check({tag, ".busy"}, 32'(busy8), 32'd0);
    check({tag, ".fa"}, 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
  endtask

  // Called at a negedge; start goes up now and is accepted on the next posedge.
  // glitch >= 0 re-asserts start with different operands during that RUN bit.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input int glitch);
    logic [8:0] sum;
    logic [8:0] mask;
    logic [8:0] part;
    sum    = {1'b0, a} + {1'b0, b} + 9'(cin);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = cin;
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      mask = (9'd1 << i) - 9'd1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 9'(cin);
      check("run.busy", 32'(busy8), 32'd1);
      check("run.done", 32'(done8), 32'd0);
      check("run.S_held", 32'(s8), 32'(prev_s8));
      check("run.Cout_held", 32'(cout8), 32'(prev_c8));
      check("run.fa_A", 32'(fa_a8), 32'(a[i]));
      check("run.fa_B", 32'(fa_b8), 32'(b[i]));
      check("run.fa_Cin", 32'(fa_cin8), 32'(part[i]));
      if (i == glitch) begin
        start8 = 1'b1;
        a8     = ~a;
        b8     = ~b;
        cin8   = ~cin;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("done.done", 32'(done8), 32'd1);
    check_idle8("done");
    check("done.S", 32'(s8), 32'(sum[7:0]));
    check("done.Cout", 32'(cout8), 32'(sum[8]));
    prev_s8 = sum[7:0];
    prev_c8 = sum[8];
  endtask

  task automatic add1(input logic a, input logic b, input logic cin);
    logic [1:0] sum;
    sum    = 2'(a) + 2'(b) + 2'(cin);
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    cin1   = cin;
    @(negedge clk);
    start1 = 1'b0;
    check("w1.busy", 32'(busy1), 32'd1);
    check("w1.fa_in", 32'({fa_a1, fa_b1, fa_cin1}), 32'({a, b, cin}));
    @(negedge clk);
    check("w1.done", 32'(done1), 32'd1);
    check("w1.busy_off", 32'(busy1), 32'd0);
    check("w1.fa_done", 32'({fa_a1, fa_b1, fa_cin1}), 32'd0);
    check("w1.sum", 32'({cout1, s1}), 32'(sum));
    @(negedge clk);
    check("w1.idle", 32'({done1, busy1, fa_a1, fa_b1, fa_cin1}), 32'd0);
    check("w1.hold", 32'({cout1, s1}), 32'(sum));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         gap;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.done8", 32'(done8), 32'd0);
    check_idle8("rst");
    check("rst.S8", 32'({cout8, s8}), 32'd0);
    check("rst.w1", 32'({busy1, done1, cout1, s1, fa_a1, fa_b1, fa_cin1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=1: full-adder truth table through the handshake
    for (int v = 0; v < 8; v++) begin
      add1(v[2], v[1], v[0]);
    end

    // T1 then return to IDLE
    add8(8'h00, 8'h00, 1'b0, -1);
    @(negedge clk);
    check("t1.idle_done", 32'(done8), 32'd0);
    check_idle8("t1.idle");

    // T2
    add8(8'hFF, 8'h01, 1'b0, -1);
    @(negedge clk);

    // T3: second add started from DONE
    add8(8'hA5, 8'h5A, 1'b1, -1);
    add8(8'h3C, 8'h0F, 1'b0, -1);
    @(negedge clk);

    // T4: start during RUN ignored, single done pulse
    add8(8'h12, 8'h34, 1'b0, 3);
    @(negedge clk);
    check("t4.single_done", 32'(done8), 32'd0);
    check_idle8("t4.idle");

    // Randomized adds, sometimes back-to-back from DONE
    for (int n = 0; n < 16; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom);
      gap = int'($urandom_range(0, 1));
      add8(ra, rb, rc, -1);
      if (gap != 0) @(negedge clk);
    end
    @(negedge clk);

    // T5: async reset in the middle of an add
    start8 = 1'b1;
    a8     = 8'hF0;
    b8     = 8'h33;
    cin8   = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("t5.pre_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5.busy", 32'(busy8), 32'd0);
    check("t5.done", 32'(done8), 32'd0);
    check("t5.result", 32'({cout8, s8}), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    prev_s8 = '0;
    prev_c8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5.no_done", 32'(done8), 32'd0);
      check_idle8("t5.after");
    end
    add8(8'h7E, 8'h81, 1'b1, -1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
